// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register for the 16-bit datapath: EX/MEM/WB
// operand bypass, load-use bubble insertion, stall hold and branch flush.
module id_ex_stage #(
  parameter int WIDTH = 16,
  parameter int RA_W  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [RA_W-1:0]  id_rs_addr,
  input  logic [RA_W-1:0]  id_rt_addr,
  input  logic [RA_W-1:0]  id_rd_addr,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [WIDTH-1:0] id_rs_val,
  input  logic [WIDTH-1:0] id_rt_val,
  input  logic [WIDTH-1:0] id_imm,
  input  logic             id_imm_sel,
  input  logic             id_rd_we,
  input  logic             id_mem_rd,
  input  logic             id_mem_wr,
  input  logic [2:0]       id_oper,
  input  logic             id_inva,
  input  logic             id_invb,
  input  logic             id_cin,
  input  logic             id_sign,
  input  logic [2:0]       id_cond,
  input  logic [WIDTH-1:0] ex_result,
  input  logic [RA_W-1:0]  mem_rd_addr,
  input  logic [RA_W-1:0]  wb_rd_addr,
  input  logic             mem_rd_we,
  input  logic             wb_rd_we,
  input  logic [WIDTH-1:0] mem_result,
  input  logic [WIDTH-1:0] wb_result,
  input  logic             ex_stall,
  input  logic             flush,
  output logic             ex_valid,
  output logic [WIDTH-1:0] ex_ina,
  output logic [WIDTH-1:0] ex_inb,
  output logic [WIDTH-1:0] ex_st_data,
  output logic [2:0]       ex_oper,
  output logic [2:0]       ex_cond,
  output logic             ex_inva,
  output logic             ex_invb,
  output logic             ex_cin,
  output logic             ex_sign,
  output logic             ex_rd_we,
  output logic             ex_mem_rd,
  output logic             ex_mem_wr,
  output logic [RA_W-1:0]  ex_rd_addr,
  output logic [15:0]      stall_cnt
);

  logic             ex_fwd_ok;
  logic             load_use;
  logic [WIDTH-1:0] fwd_rs;
  logic [WIDTH-1:0] fwd_rt;

  // A load in EX has no data yet, so it never bypasses from ex_result.
  assign ex_fwd_ok = ex_valid & ex_rd_we & ~ex_mem_rd;

  assign load_use = id_valid & ex_valid & ex_mem_rd & ex_rd_we &
                    ((id_uses_rs & (id_rs_addr == ex_rd_addr)) |
                     (id_uses_rt & (id_rt_addr == ex_rd_addr)));

  assign id_ready = ~ex_stall & ~load_use;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    fwd_rs = id_rs_val;
    if (ex_fwd_ok && ex_rd_addr == id_rs_addr)        fwd_rs = ex_result;
    else if (mem_rd_we && mem_rd_addr == id_rs_addr)  fwd_rs = mem_result;
    else if (wb_rd_we && wb_rd_addr == id_rs_addr)    fwd_rs = wb_result;
  end

  always_comb begin
    fwd_rt = id_rt_val;
    if (ex_fwd_ok && ex_rd_addr == id_rt_addr)        fwd_rt = ex_result;
    else if (mem_rd_we && mem_rd_addr == id_rt_addr)  fwd_rt = mem_result;
    else if (wb_rd_we && wb_rd_addr == id_rt_addr)    fwd_rt = wb_result;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples its inputs from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_ina     <= '0;
      ex_inb     <= '0;
      ex_st_data <= '0;
      ex_oper    <= '0;
      ex_cond    <= '0;
      ex_inva    <= 1'b0;
      ex_invb    <= 1'b0;
      ex_cin     <= 1'b0;
      ex_sign    <= 1'b0;
      ex_rd_we   <= 1'b0;
      ex_mem_rd  <= 1'b0;
      ex_mem_wr  <= 1'b0;
      ex_rd_addr <= '0;
      stall_cnt  <= '0;
    end else if (flush || (!ex_stall && load_use)) begin
      // Squash or bubble: only the side-effecting controls must be cleared.
      ex_valid  <= 1'b0;
      ex_rd_we  <= 1'b0;
      ex_mem_rd <= 1'b0;
      ex_mem_wr <= 1'b0;
      if (!flush && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end else if (!ex_stall) begin
      ex_valid   <= id_valid;
      ex_ina     <= fwd_rs;
      ex_inb     <= id_imm_sel ? id_imm : fwd_rt;
      ex_st_data <= fwd_rt;
      ex_oper    <= id_oper;
      ex_cond    <= id_cond;
      ex_inva    <= id_inva;
      ex_invb    <= id_invb;
      ex_cin     <= id_cin;
      ex_sign    <= id_sign;
      ex_rd_we   <= id_valid & id_rd_we;
      ex_mem_rd  <= id_valid & id_mem_rd;
      ex_mem_wr  <= id_valid & id_mem_wr;
      ex_rd_addr <= id_rd_addr;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, reset-mid-stall
// sequence, then randomized traffic against a behavioural model.
module tb_id_ex_stage;

  localparam int WIDTH = 16;
  localparam int RA_W  = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             id_valid, id_ready;
  logic [RA_W-1:0]  id_rs_addr, id_rt_addr, id_rd_addr;
  logic             id_uses_rs, id_uses_rt;
  logic [WIDTH-1:0] id_rs_val, id_rt_val, id_imm;
  logic             id_imm_sel, id_rd_we, id_mem_rd, id_mem_wr;
  logic [2:0]       id_oper, id_cond;
  logic             id_inva, id_invb, id_cin, id_sign;
  logic [WIDTH-1:0] ex_result, mem_result, wb_result;
  logic [RA_W-1:0]  mem_rd_addr, wb_rd_addr;
  logic             mem_rd_we, wb_rd_we, ex_stall, flush;
  logic             ex_valid;
  logic [WIDTH-1:0] ex_ina, ex_inb, ex_st_data;
  logic [2:0]       ex_oper, ex_cond;
  logic             ex_inva, ex_invb, ex_cin, ex_sign, ex_rd_we, ex_mem_rd, ex_mem_wr;
  logic [RA_W-1:0]  ex_rd_addr;
  logic [15:0]      stall_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.WIDTH(WIDTH), .RA_W(RA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_rs_val(id_rs_val), .id_rt_val(id_rt_val),
    .id_imm(id_imm), .id_imm_sel(id_imm_sel),
    .id_rd_we(id_rd_we), .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr),
    .id_oper(id_oper), .id_inva(id_inva), .id_invb(id_invb),
    .id_cin(id_cin), .id_sign(id_sign), .id_cond(id_cond),
    .ex_result(ex_result),
    .mem_rd_addr(mem_rd_addr), .wb_rd_addr(wb_rd_addr),
    .mem_rd_we(mem_rd_we), .wb_rd_we(wb_rd_we),
    .mem_result(mem_result), .wb_result(wb_result),
    .ex_stall(ex_stall), .flush(flush),
    .ex_valid(ex_valid), .ex_ina(ex_ina), .ex_inb(ex_inb), .ex_st_data(ex_st_data),
    .ex_oper(ex_oper), .ex_cond(ex_cond),
    .ex_inva(ex_inva), .ex_invb(ex_invb), .ex_cin(ex_cin), .ex_sign(ex_sign),
    .ex_rd_we(ex_rd_we), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
    .ex_rd_addr(ex_rd_addr), .stall_cnt(stall_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic             valid;
    logic [RA_W-1:0]  rs, rt, rd;
    logic             uses_rs, uses_rt;
    logic [WIDTH-1:0] rs_val, rt_val, imm;
    logic             imm_sel, ld;
    logic [WIDTH-1:0] ex_res;
    logic [RA_W-1:0]  mem_addr, wb_addr;
    logic             mem_we, wb_we;
    logic [WIDTH-1:0] mem_res, wb_res;
    logic             stall, flsh;
    logic             e_ready, e_valid;
    logic [WIDTH-1:0] e_ina, e_inb, e_st;
    logic             e_rd_we, e_mem_rd;
    logic [15:0]      e_cnt;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t dec(input logic valid, input logic [RA_W-1:0] rs, rt, rd,
                               input logic urs, urt, input logic [WIDTH-1:0] rsv, rtv, imm,
                               input logic isel, ld);
    vec_t v;
    v = '{default: '0};
    v.valid = valid; v.rs = rs; v.rt = rt; v.rd = rd;
    v.uses_rs = urs; v.uses_rt = urt; v.rs_val = rsv; v.rt_val = rtv;
    v.imm = imm; v.imm_sel = isel; v.ld = ld;
    return v;
  endfunction

  function automatic vec_t expect_(input vec_t v, input logic rdy, vld,
                                   input logic [WIDTH-1:0] ina, inb, st,
                                   input logic rwe, mrd, input logic [15:0] cnt);
    vec_t r;
    r = v;
    r.e_ready = rdy; r.e_valid = vld; r.e_ina = ina; r.e_inb = inb; r.e_st = st;
    r.e_rd_we = rwe; r.e_mem_rd = mrd; r.e_cnt = cnt;
    return r;
  endfunction

  task automatic drive_vec(input vec_t v);
    id_valid = v.valid; id_rs_addr = v.rs; id_rt_addr = v.rt; id_rd_addr = v.rd;
    id_uses_rs = v.uses_rs; id_uses_rt = v.uses_rt;
    id_rs_val = v.rs_val; id_rt_val = v.rt_val; id_imm = v.imm; id_imm_sel = v.imm_sel;
    id_rd_we = 1'b1; id_mem_rd = v.ld; id_mem_wr = 1'b0;
    id_oper = v.rd; id_cond = ~v.rd; id_inva = 1'b0; id_invb = 1'b0; id_cin = 1'b0; id_sign = 1'b0;
    ex_result = v.ex_res;
    mem_rd_addr = v.mem_addr; mem_rd_we = v.mem_we; mem_result = v.mem_res;
    wb_rd_addr = v.wb_addr; wb_rd_we = v.wb_we; wb_result = v.wb_res;
    ex_stall = v.stall; flush = v.flsh;
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic             valid;
    logic [WIDTH-1:0] ina, inb, st;
    logic [2:0]       oper, cond;
    logic             inva, invb, cin, sign, rd_we, mem_rd, mem_wr;
    logic [RA_W-1:0]  rd;
  } ex_t;

  ex_t         m;
  logic [15:0] m_cnt;

  // Operand source resolution: youngest writer of the register wins.
  function automatic logic [WIDTH-1:0] resolve(input logic [RA_W-1:0] a, input logic [WIDTH-1:0] rf);
    logic             ok [3];
    logic [RA_W-1:0]  dst[3];
    logic [WIDTH-1:0] val[3];
    ok[0] = m.valid && m.rd_we && !m.mem_rd; dst[0] = m.rd;      val[0] = ex_result;
    ok[1] = mem_rd_we;                       dst[1] = mem_rd_addr; val[1] = mem_result;
    ok[2] = wb_rd_we;                        dst[2] = wb_rd_addr;  val[2] = wb_result;
    for (int i = 0; i < 3; i++) if (ok[i] && dst[i] == a) return val[i];
    return rf;
  endfunction

  function automatic logic model_load_use();
    return id_valid && m.valid && m.mem_rd && m.rd_we &&
           ((id_uses_rs && id_rs_addr == m.rd) || (id_uses_rt && id_rt_addr == m.rd));
  endfunction

  task automatic model_step();
    logic lu;
    ex_t  n;
    lu = model_load_use();
    n  = m;
    if (flush || (!ex_stall && lu)) begin
      n.valid = 0; n.rd_we = 0; n.mem_rd = 0; n.mem_wr = 0;
      if (!flush && m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
    end else if (!ex_stall) begin
      n.valid = id_valid;
      n.ina = resolve(id_rs_addr, id_rs_val);
      n.st  = resolve(id_rt_addr, id_rt_val);
      n.inb = id_imm_sel ? id_imm : n.st;
      n.oper = id_oper; n.cond = id_cond; n.inva = id_inva; n.invb = id_invb;
      n.cin = id_cin; n.sign = id_sign; n.rd = id_rd_addr;
      n.rd_we = id_valid && id_rd_we; n.mem_rd = id_valid && id_mem_rd; n.mem_wr = id_valid && id_mem_wr;
    end
    m = n;
  endtask

  task automatic drive_rand();
    id_valid = ($urandom_range(0, 9) < 8);
    id_rs_addr = RA_W'($urandom_range(0, 3)); id_rt_addr = RA_W'($urandom_range(0, 3));
    id_rd_addr = RA_W'($urandom_range(0, 3));
    id_uses_rs = $urandom_range(0, 1); id_uses_rt = $urandom_range(0, 1);
    id_rs_val = WIDTH'($urandom); id_rt_val = WIDTH'($urandom); id_imm = WIDTH'($urandom);
    id_imm_sel = $urandom_range(0, 1);
    id_mem_rd = ($urandom_range(0, 9) < 3);
    id_mem_wr = !id_mem_rd && ($urandom_range(0, 9) < 2);
    id_rd_we = !id_mem_wr && ($urandom_range(0, 9) < 9);
    id_oper = 3'($urandom); id_cond = 3'($urandom);
    id_inva = $urandom_range(0, 1); id_invb = $urandom_range(0, 1);
    id_cin = $urandom_range(0, 1); id_sign = $urandom_range(0, 1);
    ex_result = WIDTH'($urandom); mem_result = WIDTH'($urandom); wb_result = WIDTH'($urandom);
    mem_rd_addr = RA_W'($urandom_range(0, 3)); wb_rd_addr = RA_W'($urandom_range(0, 3));
    mem_rd_we = $urandom_range(0, 1); wb_rd_we = $urandom_range(0, 1);
    ex_stall = ($urandom_range(0, 9) < 2);
    flush = ($urandom_range(0, 19) < 2);
  endtask

  task automatic compare_model();
    check("r_valid", 32'(ex_valid), 32'(m.valid));
    check("r_rd_we", 32'(ex_rd_we), 32'(m.rd_we));
    check("r_mem_rd", 32'(ex_mem_rd), 32'(m.mem_rd));
    check("r_mem_wr", 32'(ex_mem_wr), 32'(m.mem_wr));
    check("r_cnt", 32'(stall_cnt), 32'(m_cnt));
    if (m.valid) begin
      check("r_ina", 32'(ex_ina), 32'(m.ina));
      check("r_inb", 32'(ex_inb), 32'(m.inb));
      check("r_st", 32'(ex_st_data), 32'(m.st));
      check("r_ctl", {ex_oper, ex_cond, ex_inva, ex_invb, ex_cin, ex_sign, ex_rd_addr},
                     {m.oper, m.cond, m.inva, m.invb, m.cin, m.sign, m.rd});
    end
  endtask

  initial begin
    vec_t v;

    // Table: each row is one cycle; state carries from row to row.
    vecs[0] = expect_(dec(1, 2, 3, 1, 1, 1, 16'h0011, 16'h0022, 16'h0, 0, 0),
                      1, 1, 16'h0011, 16'h0022, 16'h0022, 1, 0, 0);
    v = dec(1, 1, 4, 5, 1, 1, 16'h0000, 16'h0044, 16'h0, 0, 0); v.ex_res = 16'h1234;
    vecs[1] = expect_(v, 1, 1, 16'h1234, 16'h0044, 16'h0044, 1, 0, 0);
    v = dec(1, 6, 2, 6, 1, 1, 16'h0066, 16'h0077, 16'h0, 0, 0);
    v.mem_addr = 2; v.mem_we = 1; v.mem_res = 16'hAAAA;
    v.wb_addr = 2; v.wb_we = 1; v.wb_res = 16'h5555;
    vecs[2] = expect_(v, 1, 1, 16'h0066, 16'hAAAA, 16'hAAAA, 1, 0, 0);
    v = dec(1, 6, 0, 3, 1, 0, 16'h0100, 16'h0009, 16'h0004, 1, 1); v.ex_res = 16'h0200;
    vecs[3] = expect_(v, 1, 1, 16'h0200, 16'h0004, 16'h0009, 1, 1, 0);
    v = dec(1, 3, 1, 7, 1, 1, 16'h0333, 16'h0011, 16'h0, 0, 0); v.ex_res = 16'hDEAD;
    vecs[4] = expect_(v, 0, 0, 16'h0, 16'h0, 16'h0, 0, 0, 1);
    v.ex_res = 16'h0; v.mem_addr = 3; v.mem_we = 1; v.mem_res = 16'hBEEF;
    vecs[5] = expect_(v, 1, 1, 16'hBEEF, 16'h0011, 16'h0011, 1, 0, 1);
    v = dec(1, 2, 2, 2, 1, 1, 16'h0F0F, 16'h0F0F, 16'h0, 0, 0); v.stall = 1;
    for (int i = 6; i < 9; i++) vecs[i] = expect_(v, 0, 1, 16'hBEEF, 16'h0011, 16'h0011, 1, 0, 1);
    v.flsh = 1;
    vecs[9] = expect_(v, 0, 0, 16'h0, 16'h0, 16'h0, 0, 0, 1);
    v = dec(1, 4, 5, 4, 1, 1, 16'h0040, 16'h0000, 16'hFFF0, 1, 0);
    v.wb_addr = 5; v.wb_we = 1; v.wb_res = 16'h5A5A;
    vecs[10] = expect_(v, 1, 1, 16'h0040, 16'hFFF0, 16'h5A5A, 1, 0, 1);
    vecs[11] = expect_(dec(0, 1, 1, 1, 1, 1, 16'h1, 16'h1, 16'h1, 0, 0),
                       1, 0, 16'h0, 16'h0, 16'h0, 0, 0, 1);
    vecs[12] = expect_(dec(1, 0, 0, 2, 1, 0, 16'h0001, 16'h0000, 16'h0002, 1, 1),
                       1, 1, 16'h0001, 16'h0002, 16'h0000, 1, 1, 1);
    v = dec(1, 2, 0, 3, 1, 0, 16'h0, 16'h0, 16'h0, 0, 0); v.flsh = 1;
    vecs[13] = expect_(v, 0, 0, 16'h0, 16'h0, 16'h0, 0, 0, 1);
    vecs[14] = vecs[12];
    v.flsh = 0; v.stall = 1;
    vecs[15] = expect_(v, 0, 1, 16'h0001, 16'h0002, 16'h0000, 1, 1, 1);
    v.stall = 0;
    vecs[16] = expect_(v, 0, 0, 16'h0, 16'h0, 16'h0, 0, 0, 2);

    // Reset state.
    rst_n = 1'b0;
    drive_vec(dec(0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 0));
    @(negedge clk);
    check("rst_valid", 32'(ex_valid), 0);
    check("rst_ina", 32'(ex_ina), 0);
    check("rst_cnt", 32'(stall_cnt), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      drive_vec(vecs[i]);
      #1 check($sformatf("v%0d_ready", i), 32'(id_ready), 32'(vecs[i].e_ready));
      @(posedge clk); #1;
      check($sformatf("v%0d_valid", i), 32'(ex_valid), 32'(vecs[i].e_valid));
      check($sformatf("v%0d_rd_we", i), 32'(ex_rd_we), 32'(vecs[i].e_rd_we));
      check($sformatf("v%0d_mem_rd", i), 32'(ex_mem_rd), 32'(vecs[i].e_mem_rd));
      check($sformatf("v%0d_cnt", i), 32'(stall_cnt), 32'(vecs[i].e_cnt));
      if (vecs[i].e_valid) begin
        check($sformatf("v%0d_ina", i), 32'(ex_ina), 32'(vecs[i].e_ina));
        check($sformatf("v%0d_inb", i), 32'(ex_inb), 32'(vecs[i].e_inb));
        check($sformatf("v%0d_st", i), 32'(ex_st_data), 32'(vecs[i].e_st));
      end
    end

    // Reset mid-stall with live EX contents and a nonzero bubble count.
    drive_vec(vecs[10]);
    @(posedge clk); #1;
    ex_stall = 1; flush = 0; id_valid = 1; mem_rd_we = 1; wb_rd_we = 1;
    ex_result = 16'hFFFF; mem_result = 16'hFFFF; wb_result = 16'hFFFF; id_imm = 16'hFFFF;
    @(posedge clk); #1;
    check("pre_rst_valid", 32'(ex_valid), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(ex_valid), 0);
    check("mid_rst_ina", 32'(ex_ina), 0);
    check("mid_rst_cnt", 32'(stall_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Randomized traffic against the model.
    m = '{default: '0};
    m_cnt = '0;
    for (int c = 0; c < 600; c++) begin
      drive_rand();
      #1 check("r_ready", 32'(id_ready), 32'(!ex_stall && !model_load_use()));
      model_step();
      @(posedge clk); #1;
      compare_model();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
